// File: rtl/cam_axis_pkg.sv
// cam_axis_pkg: framer state encoding and FIFO word layout (tdata in the LSBs, then tlast, then tuser).
package cam_axis_pkg;
  typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, IN_LINE, DROP} state_e;
  localparam int TDATA_LSB = 0;
  localparam int TLAST_OFS = 0;
  localparam int TUSER_OFS = 1;
  localparam int CTRL_BITS = 2;
endpackage

// File: rtl/cam_axis_fifo.sv
// cam_axis_fifo: single-clock first-word-fall-through FIFO; a write while full is accepted only alongside a read.
module cam_axis_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_wr, do_rd;
  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  always_ff @(posedge aclk)
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_q <= do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end
endmodule

// File: rtl/cam_axis_framer.sv
// cam_axis_framer: CameraLink FVAL/LVAL/DVAL to AXI4-Stream video framer with FWFT output buffer.
// Define CAM_AXIS_LINE_CHECK_EN to add cfg_line_len / line_err line-length checking.
module cam_axis_framer
  import cam_axis_pkg::*;
#(
  parameter int PIXEL_WIDTH    = 8,
  parameter int NUM_TAPS       = 3,
  parameter int FIFO_DEPTH     = 16,
  parameter int LINE_CNT_WIDTH = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            cam_valid,
  input  logic                            cam_fval,
  input  logic                            cam_lval,
  input  logic                            cam_dval,
  input  logic [NUM_TAPS*PIXEL_WIDTH-1:0] cam_data,
  output logic [NUM_TAPS*PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  input  logic                            m_axis_tready,
  input  logic                            ovf_clr,
  output logic                            overflow,
  output logic [15:0]                     frame_cnt
`ifdef CAM_AXIS_LINE_CHECK_EN
  ,
  input  logic [LINE_CNT_WIDTH-1:0]       cfg_line_len,
  output logic                            line_err
`endif
);
  localparam int DW = NUM_TAPS*PIXEL_WIDTH;
  localparam int WW = DW + CTRL_BITS;
  if (NUM_TAPS < 1 || NUM_TAPS > 4 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || LINE_CNT_WIDTH < 1) begin : g_bad_cfg
    $error("cam_axis_framer: unsupported parameter set");
  end
  state_e        state_q, state_d;
  logic          fval_q, lval_q, fval_d, lval_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          hold_user_q, hold_user_d, sof_q, sof_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          overflow_q, overflow_d;
  logic          pix, fval_rise, fval_fall, lval_fall;
  logic          push, push_last, pop, ovf_set, full, empty;
  logic [WW-1:0] wr_word, rd_word;
  assign pix       = cam_valid && cam_fval && cam_lval && cam_dval;
  assign fval_rise = cam_valid && cam_fval && !fval_q;
  assign fval_fall = cam_valid && !cam_fval && fval_q;
  assign lval_fall = cam_valid && !cam_lval && lval_q;
  assign pop       = !empty && m_axis_tready;
  assign ovf_set   = push && full && !pop;
  assign fval_d    = cam_valid ? cam_fval : fval_q;
  assign lval_d    = cam_valid ? cam_lval : lval_q;
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_user_d = hold_user_q;
    sof_d       = sof_q;
    frame_cnt_d = frame_cnt_q;
    push        = 1'b0;
    push_last   = 1'b0;
    case (state_q)
      WAIT_FRAME, DROP: if (fval_rise) begin
        state_d     = WAIT_LINE;
        sof_d       = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      WAIT_LINE: if (fval_fall) state_d = WAIT_FRAME;
        else if (pix) begin
          state_d     = IN_LINE;
          hold_d      = cam_data;
          hold_user_d = sof_q;
          sof_d       = 1'b0;
        end
      IN_LINE: if (lval_fall || fval_fall) begin
          push      = 1'b1;
          push_last = 1'b1;
          state_d   = fval_fall ? WAIT_FRAME : WAIT_LINE;
        end else if (pix) begin
          push        = 1'b1;
          hold_d      = cam_data;
          hold_user_d = 1'b0;
        end
      default: state_d = WAIT_FRAME;
    endcase
    if (ovf_set) state_d = DROP;
  end
  assign overflow_d = ovf_clr ? 1'b0 : overflow_q || ovf_set;
  always_comb begin
    wr_word                   = '0;
    wr_word[TDATA_LSB +: DW]  = hold_q;
    wr_word[DW + TLAST_OFS]   = push_last;
    wr_word[DW + TUSER_OFS]   = hold_user_q;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q     <= WAIT_FRAME;
      fval_q      <= 1'b1;
      lval_q      <= 1'b0;
      hold_q      <= '0;
      hold_user_q <= 1'b0;
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fval_q      <= fval_d;
      lval_q      <= lval_d;
      hold_q      <= hold_d;
      hold_user_q <= hold_user_d;
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  cam_axis_fifo #(.W(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (push && !ovf_set),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (rd_word),
    .full    (full),
    .empty   (empty)
  );
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : rd_word[TDATA_LSB +: DW];
  assign m_axis_tlast  = !empty && rd_word[DW + TLAST_OFS];
  assign m_axis_tuser  = !empty && rd_word[DW + TUSER_OFS];
  assign overflow      = overflow_q;
  assign frame_cnt     = frame_cnt_q;
`ifdef CAM_AXIS_LINE_CHECK_EN
  logic [LINE_CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic                      line_err_q, line_err_d;
  logic                      line_close;
  assign line_close = state_q == IN_LINE && (lval_fall || fval_fall);
  always_comb begin
    line_cnt_d = (pix && state_q == WAIT_LINE) ? LINE_CNT_WIDTH'(1) :
                 (pix && state_q == IN_LINE)   ? line_cnt_q + LINE_CNT_WIDTH'(1) : line_cnt_q;
    line_err_d = line_close && cfg_line_len != '0 && line_cnt_q != cfg_line_len;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      line_cnt_q <= '0;
      line_err_q <= 1'b0;
    end else begin
      line_cnt_q <= line_cnt_d;
      line_err_q <= line_err_d;
    end
  assign line_err = line_err_q;
`endif
endmodule

// File: tb/tb_cam_axis_framer.sv
// tb_cam_axis_framer: directed scoreboard bench for cam_axis_framer (default parameters, 3x8-bit taps).
module tb_cam_axis_framer;
  localparam int DW = 24;
  typedef struct packed {logic [DW-1:0] d; logic l; logic u;} beat_t;
  logic          aclk = 1'b0;
  logic          aresetn, cam_valid, cam_fval, cam_lval, cam_dval;
  logic [DW-1:0] cam_data, m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic          ovf_clr, overflow;
  logic [15:0]   frame_cnt;
  logic [15:0]   cfg_line_len;
  logic          line_err;
  int            errors = 0, checks = 0, beats = 0, lerr_cnt = 0;
  int            fc_exp = 0;
  logic          sof_exp = 1'b0;
  beat_t         exp_q[$];
  logic          stall = 1'b0;
  beat_t         prev;
  cam_axis_framer #(.PIXEL_WIDTH(8), .NUM_TAPS(3), .FIFO_DEPTH(16), .LINE_CNT_WIDTH(16)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cam_valid     (cam_valid),
    .cam_fval      (cam_fval),
    .cam_lval      (cam_lval),
    .cam_dval      (cam_dval),
    .cam_data      (cam_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .ovf_clr       (ovf_clr),
    .overflow      (overflow),
    .frame_cnt     (frame_cnt)
`ifdef CAM_AXIS_LINE_CHECK_EN
    ,
    .cfg_line_len  (cfg_line_len),
    .line_err      (line_err)
`endif
  );
`ifndef CAM_AXIS_LINE_CHECK_EN
  assign line_err = 1'b0;
`endif
  always #5 aclk = ~aclk;
  always @(negedge aclk) begin
    if (!aresetn) stall = 1'b0;
    else begin
      if (line_err) lerr_cnt++;
      if (stall) begin
        checks++;
        assert ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser} === {1'b1, prev})
        else begin
          errors++;
          $error("FAIL stable obs=%b/%h/%b/%b exp=1/%h/%b/%b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, prev.d, prev.l, prev.u);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        checks++;
        assert (exp_q.size() != 0)
        else begin
          errors++;
          $error("FAIL unexpected_beat obs=%h/%b/%b exp=none", m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end
        if (exp_q.size() != 0) begin
          beat_t b;
          b = exp_q.pop_front();
          checks++;
          assert ({m_axis_tdata, m_axis_tlast, m_axis_tuser} === b)
          else begin
            errors++;
            $error("FAIL beat obs=%h/%b/%b exp=%h/%b/%b", m_axis_tdata, m_axis_tlast, m_axis_tuser, b.d, b.l, b.u);
          end
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      prev  = '{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser};
    end
  end
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic f, input logic l, input logic dv, input logic [DW-1:0] d);
    cam_valid = v;
    cam_fval  = f;
    cam_lval  = l;
    cam_dval  = dv;
    cam_data  = d;
    tick();
  endtask
  task automatic frame_start();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    fc_exp++;
    sof_exp = 1'b1;
  endtask
  task automatic frame_end();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask
  task automatic line(input int n, input int keep, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = base + DW'(i) * 24'h010101;
      if (i == 1) drive(1'b0, 1'b1, 1'b1, 1'b1, 24'hdeadbe);
      drive(1'b1, 1'b1, 1'b1, 1'b1, d);
      if (i < keep) begin
        exp_q.push_back('{d: d, l: (i == n-1), u: sof_exp});
        sof_exp = 1'b0;
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
  endtask
  task automatic pix(input logic [DW-1:0] d);
    drive(1'b1, 1'b1, 1'b1, 1'b1, d);
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    tick();
    check("drain_left", exp_q.size(), 0);
    check("idle_tvalid", m_axis_tvalid, 0);
  endtask
  initial begin
    aresetn = 1'b0;
    cam_valid = 1'b1; cam_fval = 1'b1; cam_lval = 1'b1; cam_dval = 1'b1; cam_data = 24'h777777;
    m_axis_tready = 1'b1; ovf_clr = 1'b0; cfg_line_len = '0;
    repeat (3) tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    aresetn = 1'b1;
    line(4, 0, 24'h111111);
    frame_end();
    check("midframe_frame_cnt", frame_cnt, 0);
    check("midframe_tvalid", m_axis_tvalid, 0);
    frame_start();
    line(4, 4, 24'h010203);
    frame_end();
    drain();
    check("b_beats", beats, 4);
    check("b_frame_cnt", frame_cnt, fc_exp);
    frame_start();
    line(1, 1, 24'hA0A0A0);
    line(2, 2, 24'hB0B0B0);
    frame_end();
    drain();
    check("c_frame_cnt", frame_cnt, fc_exp);
    m_axis_tready = 1'b0;
    frame_start();
    line(20, 16, 24'h200000);
    check("d_overflow", overflow, 1);
    line(3, 0, 24'h300000);
    frame_end();
    check("d_full_tvalid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    drain();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("d_ovf_clr", overflow, 0);
    frame_start();
    line(3, 3, 24'h400000);
    frame_end();
    drain();
    check("d_frame_cnt", frame_cnt, fc_exp);
    m_axis_tready = 1'b0;
    frame_start();
    line(16, 16, 24'h500000);
    check("e_full_no_ovf", overflow, 0);
    pix(24'h5A0001);
    exp_q.push_back('{d: 24'h5A0001, l: 1'b0, u: 1'b0});
    m_axis_tready = 1'b1;
    pix(24'h5A0002);
    exp_q.push_back('{d: 24'h5A0002, l: 1'b1, u: 1'b0});
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("e_push_pop_full", overflow, 0);
    frame_end();
    drain();
    m_axis_tready = 1'b0;
    frame_start();
    line(16, 16, 24'h600000);
    pix(24'h6A0001);
    ovf_clr = 1'b1;
    pix(24'h6A0002);
    ovf_clr = 1'b0;
    check("f_clr_priority", overflow, 0);
    pix(24'h6A0003);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    frame_end();
    m_axis_tready = 1'b1;
    drain();
    check("f_frame_cnt", frame_cnt, fc_exp);
    m_axis_tready = 1'b0;
    frame_start();
    line(3, 0, 24'h700000);
    aresetn = 1'b0;
    cam_fval = 1'b0;
    tick();
    check("g_rst_tvalid", m_axis_tvalid, 0);
    check("g_rst_frame_cnt", frame_cnt, 0);
    fc_exp = 0;
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    frame_end();
    frame_start();
    line(2, 2, 24'h800000);
    frame_end();
    drain();
    check("g_frame_cnt", frame_cnt, fc_exp);
`ifdef CAM_AXIS_LINE_CHECK_EN
    cfg_line_len = 16'd8;
    frame_start();
    lerr_cnt = 0;
    line(8, 8, 24'h900000);
    repeat (2) tick();
    check("h_err_after_8", lerr_cnt, 0);
    line(7, 7, 24'h910000);
    repeat (2) tick();
    check("h_err_after_7", lerr_cnt, 1);
    frame_end();
    drain();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
